// File: rtl/muldiv_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : muldiv_unit
// Brief    : Iterative WIDTH-generic multiply, multiply-accumulate/subtract
//            and restoring divide engine with valid/ready handshakes.
// Revision : 1.0 - initial release
// ============================================================================
module muldiv_unit #(
    parameter int WIDTH    = 32,
    parameter int MUL_BITS = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2:0]           op,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic [2*WIDTH-1:0]   acc,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     hi,
    output logic [WIDTH-1:0]     lo
);

    localparam int c_CNT_W = $clog2(WIDTH) + 1;
    localparam logic [c_CNT_W-1:0] c_MUL_STEPS = c_CNT_W'(WIDTH / MUL_BITS);
    localparam logic [c_CNT_W-1:0] c_DIV_STEPS = c_CNT_W'(WIDTH);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE   = c_CNT_W'(1);

    // Operation kind is op[2:1]; op[0] selects the signed variant.
    localparam logic [1:0] c_KIND_MUL  = 2'b00;
    localparam logic [1:0] c_KIND_DIV  = 2'b01;
    localparam logic [1:0] c_KIND_MADD = 2'b10;
    localparam logic [1:0] c_KIND_MSUB = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_MUL  = 3'd1,
        S_DIV  = 3'd2,
        S_FIX  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t               r_state;
    logic                 r_in_ready;
    logic                 r_out_valid;
    logic [WIDTH-1:0]     r_hi;
    logic [WIDTH-1:0]     r_lo;
    logic [1:0]           r_kind;
    logic [2*WIDTH-1:0]   r_acc;
    logic [2*WIDTH-1:0]   r_mcand;
    logic [WIDTH-1:0]     r_mplier;
    logic [2*WIDTH-1:0]   r_prod;
    logic [WIDTH-1:0]     r_divisor;
    logic [WIDTH-1:0]     r_rem;
    logic [WIDTH-1:0]     r_quo;
    logic                 r_neg_p;
    logic                 r_neg_r;
    logic                 r_div0;
    logic [c_CNT_W-1:0]   r_cnt;

    // Operand decode and magnitude extraction at accept
    logic                 w_signed;
    logic                 w_is_div;
    logic                 w_a_neg;
    logic                 w_b_neg;
    logic [WIDTH-1:0]     w_a_mag;
    logic [WIDTH-1:0]     w_b_mag;
    logic                 w_b_zero;

    assign w_signed = op[0];
    assign w_is_div = (op[2:1] == c_KIND_DIV);
    assign w_a_neg  = w_signed & a[WIDTH-1];
    assign w_b_neg  = w_signed & b[WIDTH-1];
    assign w_a_mag  = w_a_neg ? (-a) : a;
    assign w_b_mag  = w_b_neg ? (-b) : b;
    assign w_b_zero = (b == '0);

    // Partial product for MUL_BITS multiplier bits
    logic [2*WIDTH-1:0]   w_pp;

    always_comb begin
        w_pp = '0;
        for (int i = 0; i < MUL_BITS; i++) begin
            if (r_mplier[i]) begin
                w_pp = w_pp + (r_mcand << i);
            end
        end
    end

    // Restoring divide step; the shifted partial remainder needs WIDTH+1 bits
    logic [WIDTH:0]       w_shift;
    logic [WIDTH-1:0]     w_diff;
    logic                 w_ge;
    logic [WIDTH-1:0]     w_rem_next;
    logic [WIDTH-1:0]     w_quo_next;

    always_comb begin
        w_shift    = {r_rem, r_quo[WIDTH-1]};
        w_ge       = (w_shift >= {1'b0, r_divisor});
        w_diff     = w_shift[WIDTH-1:0] - r_divisor;
        w_rem_next = w_ge ? w_diff : w_shift[WIDTH-1:0];
        w_quo_next = {r_quo[WIDTH-2:0], w_ge};
    end

    // Sign correction and accumulate for the FIX cycle
    logic [2*WIDTH-1:0]   w_prod_s;
    logic [2*WIDTH-1:0]   w_mac;
    logic [WIDTH-1:0]     w_quo_s;
    logic [WIDTH-1:0]     w_rem_s;
    logic [WIDTH-1:0]     w_hi_fix;
    logic [WIDTH-1:0]     w_lo_fix;

    always_comb begin
        w_prod_s = r_neg_p ? (-r_prod) : r_prod;
        w_quo_s  = r_neg_p ? (-r_quo) : r_quo;
        w_rem_s  = r_neg_r ? (-r_rem) : r_rem;
        case (r_kind)
            c_KIND_MADD: w_mac = r_acc + w_prod_s;
            c_KIND_MSUB: w_mac = r_acc - w_prod_s;
            default:     w_mac = w_prod_s;
        endcase
        if (r_kind == c_KIND_DIV) begin
            if (r_div0) begin
                w_hi_fix = r_quo;
                w_lo_fix = '1;
            end else begin
                w_hi_fix = w_rem_s;
                w_lo_fix = w_quo_s;
            end
        end else begin
            w_hi_fix = w_mac[2*WIDTH-1:WIDTH];
            w_lo_fix = w_mac[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_hi        <= '0;
            r_lo        <= '0;
            r_kind      <= '0;
            r_acc       <= '0;
            r_mcand     <= '0;
            r_mplier    <= '0;
            r_prod      <= '0;
            r_divisor   <= '0;
            r_rem       <= '0;
            r_quo       <= '0;
            r_neg_p     <= 1'b0;
            r_neg_r     <= 1'b0;
            r_div0      <= 1'b0;
            r_cnt       <= '0;
        end else if (flush) begin
            r_state     <= S_IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_kind     <= op[2:1];
                        r_acc      <= acc;
                        r_in_ready <= 1'b0;
                        r_neg_p    <= w_a_neg ^ w_b_neg;
                        if (w_is_div) begin
                            r_divisor <= w_b_mag;
                            r_rem     <= '0;
                            // A zero divisor reports the raw dividend in hi.
                            r_quo     <= w_b_zero ? a : w_a_mag;
                            r_neg_r   <= w_a_neg;
                            r_div0    <= w_b_zero;
                            r_cnt     <= c_DIV_STEPS;
                            r_state   <= w_b_zero ? S_FIX : S_DIV;
                        end else begin
                            r_mcand   <= {{WIDTH{1'b0}}, w_a_mag};
                            r_mplier  <= w_b_mag;
                            r_prod    <= '0;
                            r_neg_r   <= 1'b0;
                            r_div0    <= 1'b0;
                            r_cnt     <= c_MUL_STEPS;
                            r_state   <= S_MUL;
                        end
                    end
                end
                S_MUL: begin
                    r_prod   <= r_prod + w_pp;
                    r_mcand  <= r_mcand << MUL_BITS;
                    r_mplier <= r_mplier >> MUL_BITS;
                    r_cnt    <= r_cnt - c_CNT_ONE;
                    if (r_cnt == c_CNT_ONE) begin
                        r_state <= S_FIX;
                    end
                end
                S_DIV: begin
                    r_rem <= w_rem_next;
                    r_quo <= w_quo_next;
                    r_cnt <= r_cnt - c_CNT_ONE;
                    if (r_cnt == c_CNT_ONE) begin
                        r_state <= S_FIX;
                    end
                end
                S_FIX: begin
                    r_hi        <= w_hi_fix;
                    r_lo        <= w_lo_fix;
                    r_out_valid <= 1'b1;
                    r_state     <= S_DONE;
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign hi        = r_hi;
    assign lo        = r_lo;

endmodule
`default_nettype wire
